// File: rtl/alu_matrix_pkg.sv
// Shared opcodes, ALU select codes and FSM states for the matrix ALU sequencer.
package alu_matrix_pkg;

  typedef enum logic [2:0] {
    OPC_TRANSPOSE = 3'd0,
    OPC_ADD       = 3'd1,
    OPC_SUB       = 3'd2,
    OPC_MUL       = 3'd3,
    OPC_SCALE     = 3'd4,
    OPC_DET       = 3'd5
  } op_e;

  localparam logic [5:0] E_BASE   = 6'd0;
  localparam logic [5:0] F_BASE   = 6'd9;
  localparam logic [5:0] G_BASE   = 6'd18;
  localparam logic [5:0] DET_RD   = 6'd27;
  localparam logic [5:0] OP_T     = 6'd28;
  localparam logic [5:0] OP_ADD   = 6'd29;
  localparam logic [5:0] OP_SUB   = 6'd30;
  localparam logic [5:0] OP_MUL   = 6'd31;
  localparam logic [5:0] OP_SCALE = 6'd32;
  localparam logic [5:0] OP_DET   = 6'd33;
  localparam logic [5:0] C_LD     = 6'd40;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CALC,
    ST_READ
  } state_e;

endpackage

// File: rtl/alu_matrix_op_decode.sv
// Combinational opcode decode: operand/result counts and compute select per op.
module alu_matrix_op_decode
  import alu_matrix_pkg::*;
(
  input  logic [2:0] op,
  output logic [4:0] load_cnt,
  output logic       has_scalar,
  output logic       has_f,
  output logic [5:0] calc_sel,
  output logic [4:0] res_cnt,
  output logic       is_det,
  output logic       illegal
);

  always_comb begin
    load_cnt   = 5'd9;
    has_scalar = 1'b0;
    has_f      = 1'b0;
    calc_sel   = OP_T;
    res_cnt    = 5'd9;
    is_det     = 1'b0;
    illegal    = 1'b0;
    case (op)
      OPC_TRANSPOSE: calc_sel = OP_T;
      OPC_ADD: begin
        load_cnt = 5'd18;
        has_f    = 1'b1;
        calc_sel = OP_ADD;
      end
      OPC_SUB: begin
        load_cnt = 5'd18;
        has_f    = 1'b1;
        calc_sel = OP_SUB;
      end
      OPC_MUL: begin
        load_cnt = 5'd18;
        has_f    = 1'b1;
        calc_sel = OP_MUL;
      end
      OPC_SCALE: begin
        load_cnt   = 5'd10;
        has_scalar = 1'b1;
        calc_sel   = OP_SCALE;
      end
      OPC_DET: begin
        calc_sel = OP_DET;
        res_cnt  = 5'd1;
        is_det   = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_matrix_sequencer.sv
// Drives the matrix ALU sel/eleIn port: loads operands, issues the compute code,
// then streams the result elements out over valid/ready.
module alu_matrix_sequencer
  import alu_matrix_pkg::*;
#(
  parameter int          DW       = 32,
  parameter logic [5:0]  IDLE_SEL = 6'd63
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          err,
  output logic [5:0]    sel,
  output logic [DW-1:0] eleIn,
  input  logic [DW-1:0] eleOut
);

  state_e        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [4:0]    k_q, k_d;
  logic          rd_pend_q, rd_pend_d;
  logic [5:0]    sel_q, sel_d;
  logic [DW-1:0] ele_in_q, ele_in_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic          err_q, err_d;

  logic [2:0] dec_op;
  logic [4:0] load_cnt, res_cnt;
  logic       has_scalar, has_f, is_det, illegal;
  logic [5:0] calc_sel, k6, load_sel, read_sel, read_sel_next;

  // In IDLE the incoming opcode is decoded so illegal ones are caught before latching.
  assign dec_op = (state_q == ST_IDLE) ? cmd_op : op_q;

  alu_matrix_op_decode u_decode (
    .op         (dec_op),
    .load_cnt   (load_cnt),
    .has_scalar (has_scalar),
    .has_f      (has_f),
    .calc_sel   (calc_sel),
    .res_cnt    (res_cnt),
    .is_det     (is_det),
    .illegal    (illegal)
  );

  assign k6 = {1'b0, k_q};

  always_comb begin
    if (has_scalar)
      load_sel = (k_q == 5'd0) ? C_LD : E_BASE + k6 - 6'd1;
    else if (has_f && k_q >= 5'd9)
      load_sel = F_BASE + k6 - 6'd9;
    else
      load_sel = E_BASE + k6;
    read_sel      = is_det ? DET_RD : G_BASE + k6;
    read_sel_next = is_det ? DET_RD : G_BASE + k6 + 6'd1;
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    k_d         = k_q;
    rd_pend_d   = 1'b0;
    sel_d       = IDLE_SEL;
    ele_in_d    = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d = cmd_op;
          k_d  = 5'd0;
          if (illegal) err_d = 1'b1;
          else         state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          sel_d    = load_sel;
          ele_in_d = in_data;
          if (k_q == load_cnt - 5'd1) begin
            state_d = ST_CALC;
            k_d     = 5'd0;
          end else begin
            k_d = k_q + 5'd1;
          end
        end
      end
      ST_CALC: begin
        sel_d   = calc_sel;
        state_d = ST_READ;
        k_d     = 5'd0;
      end
      ST_READ: begin
        // Each element: issue read sel, capture a cycle later, then wait for the handshake.
        if (rd_pend_q) begin
          out_data_d  = eleOut;
          out_valid_d = 1'b1;
          out_last_d  = (k_q == res_cnt - 5'd1);
        end else if (out_valid_q) begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            if (out_last_q) begin
              state_d = ST_IDLE;
              k_d     = 5'd0;
            end else begin
              k_d       = k_q + 5'd1;
              sel_d     = read_sel_next;
              rd_pend_d = 1'b1;
            end
          end
        end else begin
          sel_d     = read_sel;
          rd_pend_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= 3'd0;
      k_q         <= 5'd0;
      rd_pend_q   <= 1'b0;
      sel_q       <= IDLE_SEL;
      ele_in_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      k_q         <= k_d;
      rd_pend_q   <= rd_pend_d;
      sel_q       <= sel_d;
      ele_in_q    <= ele_in_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign err       = err_q;
  assign sel       = sel_q;
  assign eleIn     = ele_in_q;

endmodule

// File: tb/tb_alu_matrix_sequencer.sv
// Directed bench for alu_matrix_sequencer with a behavioural 3x3 matrix ALU attached.
module tb_alu_matrix_sequencer;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready;
  logic [2:0]    cmd_op;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready, out_last, err;
  logic [DW-1:0] out_data, eleIn, eleOut;
  logic [5:0]    sel;

  always #5 clk = ~clk;

  alu_matrix_sequencer #(.DW(DW), .IDLE_SEL(6'd63)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .err       (err),
    .sel       (sel),
    .eleIn     (eleIn),
    .eleOut    (eleOut)
  );

  // Behavioural ALU: load registers on sel, compute G on op codes, eleOut combinational.
  logic [31:0] me [9];
  logic [31:0] mf [9];
  logic [31:0] mg [9];
  logic [31:0] mc, mdet;
  int          sel_i;

  always_comb sel_i = int'(sel);

  function automatic logic [31:0] g_el(input int s, input int i);
    logic [31:0] acc;
    acc = 32'd0;
    case (s)
      28: acc = me[(i % 3) * 3 + i / 3];
      29: acc = me[i] + mf[i];
      30: acc = me[i] - mf[i];
      31: for (int m = 0; m < 3; m++) acc = acc + me[(i / 3) * 3 + m] * mf[m * 3 + (i % 3)];
      32: acc = mc * me[i];
      default: acc = 32'd0;
    endcase
    return acc;
  endfunction

  function automatic logic [31:0] det3();
    int a, b, c, d, e, f, g, h, k;
    a = int'(me[0]); b = int'(me[1]); c = int'(me[2]);
    d = int'(me[3]); e = int'(me[4]); f = int'(me[5]);
    g = int'(me[6]); h = int'(me[7]); k = int'(me[8]);
    return 32'(a * (e * k - f * h) - b * (d * k - f * g) + c * (d * h - e * g));
  endfunction

  always @(posedge clk) begin
    if (sel_i <= 8) me[sel_i] <= eleIn;
    else if (sel_i <= 17) mf[sel_i - 9] <= eleIn;
    else if (sel_i == 40) mc <= eleIn;
    else if (sel_i == 33) mdet <= det3();
    else if (sel_i >= 28 && sel_i <= 32)
      for (int i = 0; i < 9; i++) mg[i] <= g_el(sel_i, i);
  end

  always_comb begin
    eleOut = '0;
    if (sel_i >= 18 && sel_i <= 26) eleOut = mg[sel_i - 18];
    else if (sel_i == 27)           eleOut = mdet;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       trace_en = 1'b0;
  logic [5:0] trace [$];
  always @(negedge clk) if (trace_en && sel != 6'd63) trace.push_back(sel);

  int          n_checks = 0;
  int          n_errs   = 0;
  int          acc_cyc;
  logic [31:0] beats [$];
  logic [31:0] expv  [$];
  logic [5:0]  exp_tr [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [2:0] op);
    int w;
    w = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("cmd_accept", 32'(cmd_ready), 32'd1);
    acc_cyc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic load_beats(input int gap_at);
    int w;
    for (int i = 0; i < beats.size(); i++) begin
      if (i == gap_at) begin
        in_valid = 1'b0;
        @(negedge clk);
        check("gap_sel_a", 32'(sel), 32'd63);
        @(negedge clk);
        check("gap_sel_b", 32'(sel), 32'd63);
      end
      in_valid = 1'b1;
      in_data  = beats[i];
      w = 0;
      while (!in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic read_results(input int stall_idx, input int stall_len, input bit chk_lat);
    int idx, rem, w, first_c, last_c;
    idx = 0; rem = stall_len; w = 0; first_c = 0; last_c = 0;
    out_ready = 1'b1;
    while (idx < expv.size() && w < 400) begin
      if (out_valid) begin
        if (idx == stall_idx && rem > 0) begin
          out_ready = 1'b0;
          check("stall_data", out_data, expv[idx]);
          check("stall_last", 32'(out_last), 32'd0);
          check("stall_sel", 32'(sel), 32'd63);
          rem--;
        end else begin
          out_ready = 1'b1;
          if (idx == 0) first_c = cyc;
          check($sformatf("out_data[%0d]", idx), out_data, expv[idx]);
          check($sformatf("out_last[%0d]", idx), 32'(out_last), 32'(idx == expv.size() - 1));
          last_c = cyc;
          idx++;
        end
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      w++;
    end
    check("read_count", 32'(idx), 32'(expv.size()));
    check("end_idle", 32'(cmd_ready), 32'd1);
    check("end_valid", 32'(out_valid), 32'd0);
    if (chk_lat) begin
      check("lat_first", 32'(first_c - acc_cyc), 32'd22);
      check("lat_last", 32'(last_c - acc_cyc), 32'd38);
    end
  endtask

  task automatic run(input string name, input logic [2:0] op, input int gap_at,
                     input int stall_idx, input int stall_len, input bit chk_lat);
    int e0;
    e0 = n_errs;
    send_cmd(op);
    load_beats(gap_at);
    read_results(stall_idx, stall_len, chk_lat);
    $display("cmd %s op=%0d beats=%0d results=%0d new_errors=%0d",
             name, op, beats.size(), expv.size(), n_errs - e0);
  endtask

  task automatic check_trace(input string tag);
    check({tag, "_len"}, 32'(trace.size()), 32'(exp_tr.size()));
    for (int i = 0; i < exp_tr.size() && i < trace.size(); i++)
      check($sformatf("%s[%0d]", tag, i), 32'(trace[i]), 32'(exp_tr[i]));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_sel", 32'(sel), 32'd63);
    check("rst_eleIn", eleIn, 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // add with sel trace and latency
    beats = '{1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,16,17,18};
    expv  = '{11,13,15,17,19,21,23,25,27};
    trace.delete();
    trace_en = 1'b1;
    run("add", 3'd1, -1, -1, 0, 1'b1);
    trace_en = 1'b0;
    exp_tr.delete();
    for (int i = 0; i < 18; i++) exp_tr.push_back(6'(i));
    exp_tr.push_back(6'd29);
    for (int i = 18; i < 27; i++) exp_tr.push_back(6'(i));
    check_trace("add_sel");

    // mul by identity with output backpressure on the 4th element
    beats = '{1,2,3,4,5,6,7,8,9, 1,0,0,0,1,0,0,0,1};
    expv  = '{1,2,3,4,5,6,7,8,9};
    run("mul", 3'd3, -1, 3, 5, 1'b0);

    // transpose with an input gap before beat 4
    beats = '{1,2,3,4,5,6,7,8,9};
    expv  = '{1,4,7,2,5,8,3,6,9};
    run("transpose", 3'd0, 4, -1, 0, 1'b0);

    // sub
    beats = '{10,11,12,13,14,15,16,17,18, 1,2,3,4,5,6,7,8,9};
    expv  = '{9,9,9,9,9,9,9,9,9};
    run("sub", 3'd2, -1, -1, 0, 1'b0);

    // scale by 3
    beats = '{3,1,2,3,4,5,6,7,8,9};
    expv  = '{3,6,9,12,15,18,21,24,27};
    trace.delete();
    trace_en = 1'b1;
    run("scale", 3'd4, -1, -1, 0, 1'b0);
    trace_en = 1'b0;
    check("scale_len", 32'(trace.size()), 32'd20);
    if (trace.size() > 10) begin
      check("scale_first_sel", 32'(trace[0]), 32'd40);
      check("scale_calc_sel", 32'(trace[10]), 32'd32);
    end

    // det of diag(2,3,4)
    beats = '{2,0,0,0,3,0,0,0,4};
    expv  = '{24};
    trace.delete();
    trace_en = 1'b1;
    run("det", 3'd5, -1, -1, 0, 1'b0);
    trace_en = 1'b0;
    exp_tr.delete();
    for (int i = 0; i < 9; i++) exp_tr.push_back(6'(i));
    exp_tr.push_back(6'd33);
    exp_tr.push_back(6'd27);
    check_trace("det_sel");

    // illegal opcode
    check("err_before", 32'(err), 32'd0);
    cmd_valid = 1'b1;
    cmd_op    = 3'd7;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("err_pulse", 32'(err), 32'd1);
    check("err_cmd_ready", 32'(cmd_ready), 32'd1);
    check("err_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("err_clear", 32'(err), 32'd0);
    check("err_in_ready2", 32'(in_ready), 32'd0);
    check("err_sel", 32'(sel), 32'd63);
    $display("cmd illegal op=7 err_seen");

    // reset after 5 load beats, then a clean add
    beats = '{1,2,3,4,5};
    send_cmd(3'd1);
    load_beats(-1);
    reset = 1'b1;
    #1;
    check("mid_rst_sel", 32'(sel), 32'd63);
    check("mid_rst_eleIn", eleIn, 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", out_data, 32'd0);
    check("mid_rst_out_last", 32'(out_last), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    $display("cmd reset mid-load beats=5");
    beats = '{1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,16,17,18};
    expv  = '{11,13,15,17,19,21,23,25,27};
    run("add_after_reset", 3'd1, -1, -1, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_matrix_sequencer.md
Name: alu_matrix_sequencer

Overview:
Host-side driver for the 3x3 matrix ALU's sel/eleIn/eleOut port. Accepts one command (operation code) plus a stream of operand elements, and loads them into the ALU with the matching sel codes. Issues the compute sel, then reads the result back element by element onto a valid/ready output stream. Sits between the host/command fabric and the matrix ALU instance.

Parameters:
DW, 32, element data width; matches the ALU eleIn/eleOut width.
IDLE_SEL, 63, sel value driven when not loading, computing or reading; must not be a load or compute code.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
cmd_valid  input  1  command offered.
cmd_ready  output  1  high only in IDLE.
cmd_op  input  3  0 transpose, 1 add, 2 sub, 3 mul, 4 scale, 5 det; 6-7 illegal.
in_valid  input  1  operand element offered.
in_ready  output  1  high only in LOAD.
in_data  input  DW  operand element.
out_valid  output  1  result element valid.
out_ready  input  1  downstream accepts result.
out_data  output  DW  result element.
out_last  output  1  marks the final result element of a command.
err  output  1  one-cycle pulse when an illegal opcode is accepted.
sel  output  6  registered ALU select.
eleIn  output  DW  registered ALU element input.
eleOut  input  DW  ALU element output; combinational from sel.

Behaviour:
- Reset values: sel=IDLE_SEL, eleIn=0, out_valid=0, out_data=0, out_last=0, err=0. FSM goes to IDLE. Reset mid-operation abandons the command; no partial output remains.
- States: IDLE -> LOAD -> CALC -> READ -> IDLE.
- IDLE: cmd_ready=1. On cmd_valid, latch the op.
  - Legal op: go to LOAD.
  - Illegal op: pulse err next cycle and stay in IDLE.
- LOAD: in_ready=1. Each accepted beat registers sel=load code and eleIn=in_data for exactly one cycle; with no beat, sel=IDLE_SEL.
- Load sequences (row-major, index k):
  - transpose and det: E only, sel 0..8 (9 beats).
  - add, sub, mul: E then F, sel 0..17 (18 beats).
  - scale: c first (sel 40), then E sel 0..8 (10 beats).
- After the last beat is accepted, move to CALC.
  - CALC lasts one cycle, after the final load sel cycle.
  - CALC drives sel = 28 (transpose), 29 (add), 30 (sub), 31 (mul), 32 (scale) or 33 (det).
  - The ALU registers the result at the edge ending the CALC cycle.
- READ, per element k:
  - Drive sel=18+k (det: sel=27) for one cycle.
  - Capture eleOut into out_data at the next edge and assert out_valid.
  - While out_valid && !out_ready: hold out_data, out_valid, out_last and k; drive sel=IDLE_SEL.
  - On the handshake, advance k and present the next sel in the following cycle.
- Output count: 9 elements (det: 1). out_last=1 on the final element. After that handshake, return to IDLE.
- Element counter: 5 bits, cleared on command accept and on each state change.
- Arithmetic: none in this block. Data passes unmodified; wrap and sign semantics belong to the ALU.
- Latency (add, in_valid and out_ready held high, cmd accepted at cycle 0):
  - Beats accepted cycles 1-18.
  - CALC cycle 20.
  - First out_valid cycle 22.
  - Later results every 2 cycles; out_last at cycle 38.
- Simultaneous events: a new cmd_valid is ignored outside IDLE. The cycle after the final out handshake is IDLE, so back-to-back commands are allowed.

Decomposition:
- Package alu_matrix_pkg:
  - Opcode enum.
  - Sel constants: E_BASE=0, F_BASE=9, G_BASE=18, DET_RD=27, OP_T=28, OP_ADD=29, OP_SUB=30, OP_MUL=31, OP_SCALE=32, OP_DET=33, C_LD=40.
  - State typedef.
- One sub-module, alu_matrix_op_decode (combinational). Maps op to: load count, has_scalar, has_F, compute sel, result count, is_det, illegal.

Test Plan:
- Add, E=1..9, F=10..18 -> 9 outputs 11,13,...,27; out_last only on 27; sel sequence 0..17, 29, 18..26.
- Mul, E=1..9, F=identity -> outputs 1..9. Transpose of E=1..9 -> 1,4,7,2,5,8,3,6,9.
- Scale, c=3 then E=1..9 -> first sel 40, outputs 3,6,...,27.
- Det of diag(2,3,4) -> single output 24 with out_last=1, read sel 27.
- Backpressure and gaps:
  - out_ready low 5 cycles on element 4: out_data stable, no skipped or duplicated element.
  - in_valid gaps mid-load: sel=63 during gaps, results unchanged.
- Error and reset:
  - cmd_op=7 -> err pulse one cycle, state stays IDLE, no in_ready.
  - reset asserted after 5 load beats -> all outputs return to reset values; a new add command then gives correct results.
